// File: rtl/axi_warb_pkg.sv
// Shared types and constants for the AXI write-channel arbiter.
// The B-channel response watchdog is built only when AXI_WARB_BTIMEOUT_EN is defined.
package axi_warb_pkg;

  // Default-configuration field widths (ID_W=4, ADDR_W=32, DATA_W=32)
  localparam int ID_W_DEF   = 4;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam int AW_W = ID_W_DEF + ADDR_W_DEF + 8;
  localparam int W_W  = DATA_W_DEF + DATA_W_DEF / 8 + 1;
  localparam int B_W  = ID_W_DEF + 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [ID_W_DEF-1:0]   id;
    logic [ADDR_W_DEF-1:0] addr;
    logic [7:0]            len;
  } aw_pld_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0]   data;
    logic [DATA_W_DEF/8-1:0] strb;
    logic                    last;
  } w_pld_t;

  typedef struct packed {
    logic [ID_W_DEF-1:0] id;
    logic [1:0]          resp;
  } b_pld_t;

`ifdef AXI_WARB_BTIMEOUT_EN
  typedef enum logic [2:0] {ST_IDLE, ST_AW, ST_W, ST_B, ST_BERR} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_e;
`endif

endpackage

// File: rtl/axi_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_i, with wrap-around.
module axi_rr_arbiter
  import axi_warb_pkg::*;
#(
  parameter int NUM_M = 2
) (
  input  logic [NUM_M-1:0]         req_i,
  input  logic [$clog2(NUM_M)-1:0] last_i,
  output logic [NUM_M-1:0]         gnt_oh_o,
  output logic [$clog2(NUM_M)-1:0] gnt_idx_o
);

  localparam int IDX_W = $clog2(NUM_M);

  // Scan from last_i+1 upward; the first hit wins, so last_i itself has lowest priority
  always_comb begin
    int  cand;
    logic found;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = 0;
    for (int off = 1; off <= NUM_M; off++) begin
      cand = (int'(last_i) + off) % NUM_M;
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        gnt_oh_o[cand]  = 1'b1;
        gnt_idx_o       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// N-master to 1-slave AXI write arbiter (AW/W/B), round-robin, one transaction in flight.
// Optional macro AXI_WARB_BTIMEOUT_EN adds a B-response watchdog that answers SLVERR.
module axi_wr_arbiter
  import axi_warb_pkg::*;
#(
  parameter int NUM_M       = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ID_W        = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                                  aclk,
  input  logic                                  arst,
  input  logic [NUM_M-1:0]                      m_awvalid,
  output logic [NUM_M-1:0]                      m_awready,
  input  logic [NUM_M*(ID_W+ADDR_W+8)-1:0]      m_awpld,
  input  logic [NUM_M-1:0]                      m_wvalid,
  output logic [NUM_M-1:0]                      m_wready,
  input  logic [NUM_M*(DATA_W+DATA_W/8+1)-1:0]  m_wpld,
  output logic [NUM_M-1:0]                      m_bvalid,
  input  logic [NUM_M-1:0]                      m_bready,
  output logic [NUM_M*(ID_W+2)-1:0]             m_bpld,
  output logic                                  s_awvalid,
  input  logic                                  s_awready,
  output logic [ID_W+ADDR_W+8-1:0]              s_awpld,
  output logic                                  s_wvalid,
  input  logic                                  s_wready,
  output logic [DATA_W+DATA_W/8+1-1:0]          s_wpld,
  input  logic                                  s_bvalid,
  output logic                                  s_bready,
  input  logic [ID_W+2-1:0]                     s_bpld,
  output logic [$clog2(NUM_M)-1:0]              grant,
  output logic                                  busy,
  output logic                                  timeout_err
);

  localparam int AWPW  = ID_W + ADDR_W + 8;
  localparam int WPW   = DATA_W + DATA_W / 8 + 1;
  localparam int BPW   = ID_W + 2;
  localparam int IDX_W = $clog2(NUM_M);

  if (NUM_M < 2 || NUM_M > 8) begin : g_bad_num_m
    $error("axi_wr_arbiter: NUM_M must be in 2..8");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("axi_wr_arbiter: TIMEOUT_CYC must be at least 2");
  end

  state_e           state_q;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] last_grant_q;
  logic [7:0]       beat_cnt_q;

  logic [NUM_M-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;

  logic [AWPW-1:0]  aw_sel;
  logic [WPW-1:0]   w_sel;
  logic             wvalid_sel;
  logic             bready_sel;

`ifdef AXI_WARB_BTIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             timeout_err_q;
  logic             stale_q;
  logic [ID_W-1:0]  awid_q;
  logic [AWPW-1:0]  aw_pick;
`endif

  axi_rr_arbiter #(.NUM_M(NUM_M)) u_rr (
    .req_i     (m_awvalid),
    .last_i    (last_grant_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx)
  );

  // Route the owning master's live AW/W payload and handshake inputs toward the slave
  always_comb begin
    aw_sel     = '0;
    w_sel      = '0;
    wvalid_sel = 1'b0;
    bready_sel = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant_q == IDX_W'(i)) begin
        aw_sel     = m_awpld[i*AWPW +: AWPW];
        w_sel      = m_wpld[i*WPW +: WPW];
        wvalid_sel = m_wvalid[i];
        bready_sel = m_bready[i];
      end
    end
  end

`ifdef AXI_WARB_BTIMEOUT_EN
  // AW payload of the master about to be granted, so its ID can back a SLVERR reply
  always_comb begin
    aw_pick = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (pick_idx == IDX_W'(i)) aw_pick = m_awpld[i*AWPW +: AWPW];
    end
  end
`endif

  // Channel steering: only the owner sees ready/bvalid, everyone else is held off
  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bpld    = '0;
    s_awvalid = 1'b0;
    s_awpld   = '0;
    s_wvalid  = 1'b0;
    s_wpld    = '0;
    s_bready  = 1'b0;
    unique case (state_q)
      ST_AW: begin
        s_awvalid          = 1'b1;
        s_awpld            = aw_sel;
        m_awready[grant_q] = s_awready;
      end
      ST_W: begin
        s_wvalid          = wvalid_sel;
        s_wpld            = w_sel;
        m_wready[grant_q] = s_wready;
      end
      ST_B: begin
        m_bvalid[grant_q] = s_bvalid;
        s_bready          = bready_sel;
        for (int i = 0; i < NUM_M; i++) begin
          if (grant_q == IDX_W'(i)) m_bpld[i*BPW +: BPW] = s_bpld;
        end
      end
`ifdef AXI_WARB_BTIMEOUT_EN
      ST_BERR: begin
        m_bvalid[grant_q] = 1'b1;
        for (int i = 0; i < NUM_M; i++) begin
          if (grant_q == IDX_W'(i)) m_bpld[i*BPW +: BPW] = {awid_q, RESP_SLVERR};
        end
      end
`endif
      default: ;
    endcase
`ifdef AXI_WARB_BTIMEOUT_EN
    // Soak up the late response of a timed-out transaction outside the B phase
    if (stale_q && (state_q inside {ST_IDLE, ST_AW, ST_W})) s_bready = 1'b1;
`endif
  end

  // Transaction FSM: IDLE -> AW -> W -> B (-> BERR) -> IDLE, grant held end to end
  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      last_grant_q  <= IDX_W'(NUM_M - 1);
      beat_cnt_q    <= '0;
`ifdef AXI_WARB_BTIMEOUT_EN
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
      stale_q       <= 1'b0;
      awid_q        <= '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (|pick_oh) begin
            grant_q <= pick_idx;
            state_q <= ST_AW;
`ifdef AXI_WARB_BTIMEOUT_EN
            awid_q  <= aw_pick[AWPW-1 -: ID_W];
`endif
          end
        end
        ST_AW: begin
          if (s_awready) begin
            beat_cnt_q <= aw_sel[7:0];
            state_q    <= ST_W;
          end
        end
        ST_W: begin
          // wlast alone ends the burst; a length mismatch is not policed here
          if (wvalid_sel && s_wready) begin
            if (beat_cnt_q != 8'd0) beat_cnt_q <= beat_cnt_q - 8'd1;
            if (w_sel[0]) begin
              state_q <= ST_B;
`ifdef AXI_WARB_BTIMEOUT_EN
              tmo_cnt_q <= '0;
`endif
            end
          end
        end
        ST_B: begin
          if (s_bvalid && bready_sel) begin
            last_grant_q <= grant_q;
            state_q      <= ST_IDLE;
          end
`ifdef AXI_WARB_BTIMEOUT_EN
          else if (!s_bvalid && tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            state_q       <= ST_BERR;
            timeout_err_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
`endif
        end
`ifdef AXI_WARB_BTIMEOUT_EN
        ST_BERR: begin
          if (bready_sel) begin
            last_grant_q <= grant_q;
            stale_q      <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
`ifdef AXI_WARB_BTIMEOUT_EN
      if (stale_q && s_bvalid && (state_q inside {ST_IDLE, ST_AW, ST_W})) stale_q <= 1'b0;
`endif
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);

`ifdef AXI_WARB_BTIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter (NUM_M=2, default widths).
// The watchdog scenario runs only when AXI_WARB_BTIMEOUT_EN is defined.
module tb_axi_wr_arbiter;
  import axi_warb_pkg::*;

`ifdef AXI_WARB_BTIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 256;
`endif

  logic        aclk = 1'b0;
  logic        arst;
  logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [87:0] m_awpld;
  logic [73:0] m_wpld;
  logic [11:0] m_bpld;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [43:0] s_awpld;
  logic [36:0] s_wpld;
  logic [5:0]  s_bpld;
  logic [0:0]  grant;
  logic        busy, timeout_err;

  aw_pld_t awp [2];
  w_pld_t  wp  [2];

  int n_assert = 0;
  int n_fail   = 0;

  assign m_awpld = {awp[1], awp[0]};
  assign m_wpld  = {wp[1], wp[0]};

  axi_wr_arbiter #(
    .NUM_M(2), .ADDR_W(32), .DATA_W(32), .ID_W(4), .TIMEOUT_CYC(TMO)
  ) dut (
    .aclk(aclk), .arst(arst),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awpld(m_awpld),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wpld(m_wpld),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bpld(m_bpld),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awpld(s_awpld),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wpld(s_wpld),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bpld(s_bpld),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entry: DUT in AW granted to m. Runs AW (after aw_wait stalls), beats, OKAY response.
  task automatic txn(input int m, input int beats, input int aw_wait);
    logic [1:0] oh;
    oh = 2'(1 << m);
    chk("txn_grant", grant, m);
    chk("txn_awvalid", s_awvalid, 1);
    chk("txn_awpld", s_awpld, awp[m]);
    for (int w = 0; w < aw_wait; w++) begin
      s_awready = 1'b0;
      #1;
      chk("txn_awready_wait", m_awready, 0);
      cyc();
      chk("txn_awvalid_hold", s_awvalid, 1);
    end
    s_awready = 1'b1;
    #1;
    chk("txn_awready", m_awready, oh);
    cyc();
    s_awready    = 1'b0;
    m_awvalid[m] = 1'b0;
    for (int b = 0; b < beats; b++) begin
      wp[m].data  = 32'hD000_0000 + 32'(m * 256 + b);
      wp[m].strb  = 4'hF;
      wp[m].last  = (b == beats - 1);
      m_wvalid[m] = 1'b1;
      s_wready    = 1'b1;
      #1;
      chk("txn_wvalid", s_wvalid, 1);
      chk("txn_wpld", s_wpld, wp[m]);
      chk("txn_wready", m_wready, oh);
      cyc();
    end
    m_wvalid[m] = 1'b0;
    s_wready    = 1'b0;
    s_bvalid    = 1'b1;
    s_bpld      = {awp[m].id, 2'b00};
    m_bready[m] = 1'b1;
    #1;
    chk("txn_bvalid", m_bvalid, oh);
    chk("txn_bpld", m_bpld[m*6 +: 6], {awp[m].id, 2'b00});
    chk("txn_bready", s_bready, 1);
    cyc();
    s_bvalid    = 1'b0;
    m_bready[m] = 1'b0;
    #1;
    chk("txn_busy_after_b", busy, 0);
  endtask

  initial begin
    int c;
    int k;
    arst = 1'b1;
    m_awvalid = '0; m_wvalid = '0; m_bready = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bpld = '0;
    awp[0] = '0; awp[1] = '0; wp[0] = '0; wp[1] = '0;

    // Reset values
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_awvalid", s_awvalid, 0);
    chk("rst_wvalid", s_wvalid, 0);
    chk("rst_bready", s_bready, 0);
    chk("rst_m_ready", {m_awready, m_wready, m_bvalid}, 0);
    chk("rst_timeout_err", timeout_err, 0);
    arst = 1'b0;
    cyc();

    // Single master, 4-beat burst, slave AW stall of 2 cycles
    awp[0] = '{id: 4'd3, addr: 32'h100, len: 8'd3};
    m_awvalid[0] = 1'b1;
    #1;
    chk("t1_awvalid_cycN", s_awvalid, 0);
    cyc();
    chk("t1_awvalid_cycN1", s_awvalid, 1);
    chk("t1_busy", busy, 1);
    m_wvalid[0] = 1'b1;
    #1;
    chk("t1_wready_in_aw", m_wready, 0);
    chk("t1_wvalid_in_aw", s_wvalid, 0);
    m_wvalid[0] = 1'b0;
    txn(0, 4, 2);

    // Two masters together from reset: strict alternation 0,1,0,1
    arst = 1'b1;
    cyc();
    arst = 1'b0;
    cyc();
    awp[0] = '{id: 4'd1, addr: 32'h200, len: 8'd0};
    awp[1] = '{id: 4'd2, addr: 32'h300, len: 8'd1};
    m_awvalid = 2'b11;
    cyc();
    txn(0, 1, 0);
    m_awvalid[0] = 1'b1;
    cyc();
    txn(1, 2, 0);
    awp[1].len = 8'd0;
    m_awvalid = 2'b11;
    cyc();
    txn(0, 1, 0);
    cyc();
    txn(1, 1, 0);

    // Master 1 requests while master 0 is in W
    awp[0] = '{id: 4'd4, addr: 32'h400, len: 8'd1};
    m_awvalid[0] = 1'b1;
    cyc();
    chk("t3_grant0", grant, 0);
    s_awready = 1'b1;
    #1;
    cyc();
    s_awready = 1'b0;
    m_awvalid[0] = 1'b0;
    awp[1] = '{id: 4'd6, addr: 32'h600, len: 8'd0};
    m_awvalid[1] = 1'b1;
    wp[1] = '{data: 32'h1111_1111, strb: 4'hF, last: 1'b1};
    m_wvalid[1] = 1'b1;
    for (int b = 0; b < 2; b++) begin
      wp[0] = '{data: 32'hC000_0000 + 32'(b), strb: 4'hF, last: (b == 1)};
      m_wvalid[0] = 1'b1;
      s_wready = 1'b1;
      #1;
      chk("t3_wready_owner_only", m_wready, 2'b01);
      chk("t3_awready_blocked", m_awready, 2'b00);
      chk("t3_wpld_owner", s_wpld, wp[0]);
      cyc();
    end
    m_wvalid[0] = 1'b0;
    s_wready = 1'b0;
    #1;
    chk("t3_b_awready", m_awready, 0);
    chk("t3_b_wready", m_wready, 0);
    s_bvalid = 1'b1;
    s_bpld = {4'd4, 2'b00};
    m_bready[0] = 1'b1;
    #1;
    chk("t3_bvalid", m_bvalid, 2'b01);
    cyc();
    s_bvalid = 1'b0;
    m_bready = '0;
    #1;
    chk("t3_idle_gap", busy, 0);
    cyc();
    chk("t3_aw_wready_blocked", m_wready, 0);
    chk("t3_aw_wvalid_blocked", s_wvalid, 0);
    txn(1, 1, 0);

    // Slave W backpressure 1-0-1-0 over an 8-beat burst
    awp[0] = '{id: 4'd7, addr: 32'h800, len: 8'd7};
    m_awvalid[0] = 1'b1;
    cyc();
    s_awready = 1'b1;
    #1;
    cyc();
    s_awready = 1'b0;
    m_awvalid[0] = 1'b0;
    k = 0;
    c = 0;
    while (c < 40 && k < 8) begin
      wp[0] = '{data: 32'hB000_0000 + 32'(k), strb: 4'hF, last: (k == 7)};
      m_wvalid[0] = 1'b1;
      s_wready = (c % 2 == 0);
      #1;
      chk("t4_wpld", s_wpld, wp[0]);
      chk("t4_wready", m_wready, {1'b0, s_wready});
      if (m_wready[0]) k++;
      cyc();
      c++;
    end
    chk("t4_handshakes", k, 8);
    chk("t4_cycles", c, 15);
    wp[0] = '{data: 32'hDEAD_BEEF, strb: 4'hF, last: 1'b0};
    s_wready = 1'b1;
    #1;
    chk("t4_left_w", m_wready, 0);
    m_wvalid[0] = 1'b0;
    s_wready = 1'b0;
    s_bvalid = 1'b1;
    s_bpld = {4'd7, 2'b00};
    m_bready[0] = 1'b1;
    #1;
    chk("t4_bvalid", m_bvalid, 2'b01);
    cyc();
    s_bvalid = 1'b0;
    m_bready = '0;

    // Reset pulsed mid-W after 2 of 4 beats
    awp[1] = '{id: 4'd9, addr: 32'hA00, len: 8'd3};
    m_awvalid[1] = 1'b1;
    cyc();
    chk("t5_grant1", grant, 1);
    s_awready = 1'b1;
    #1;
    cyc();
    s_awready = 1'b0;
    m_awvalid[1] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wp[1] = '{data: 32'hE000_0000 + 32'(b), strb: 4'hF, last: 1'b0};
      m_wvalid[1] = 1'b1;
      s_wready = 1'b1;
      #1;
      chk("t5_wready", m_wready, 2'b10);
      cyc();
    end
    arst = 1'b1;
    s_bvalid = 1'b1;
    m_bready = 2'b10;
    cyc();
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_wvalid", s_wvalid, 0);
    chk("t5_rst_wready", m_wready, 0);
    chk("t5_rst_bvalid", m_bvalid, 0);
    chk("t5_rst_awvalid", s_awvalid, 0);
    chk("t5_rst_bready", s_bready, 0);
    arst = 1'b0;
    m_wvalid = '0; s_wready = 1'b0; s_bvalid = 1'b0; m_bready = '0;
    awp[0] = '{id: 4'd10, addr: 32'hB00, len: 8'd0};
    m_awvalid = 2'b11;
    cyc();
    chk("t5_regrant0", grant, 0);
    txn(0, 1, 0);
    cyc();
    txn(1, 4, 0);

`ifdef AXI_WARB_BTIMEOUT_EN
    // Slave withholds B: SLVERR after TMO cycles, late response absorbed
    awp[0] = '{id: 4'd5, addr: 32'hC00, len: 8'd0};
    m_awvalid[0] = 1'b1;
    cyc();
    s_awready = 1'b1;
    #1;
    cyc();
    s_awready = 1'b0;
    m_awvalid[0] = 1'b0;
    wp[0] = '{data: 32'h5555_0000, strb: 4'hF, last: 1'b1};
    m_wvalid[0] = 1'b1;
    s_wready = 1'b1;
    #1;
    cyc();
    m_wvalid[0] = 1'b0;
    s_wready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        chk("t6_still_b", m_bvalid, 0);
        chk("t6_no_err_yet", timeout_err, 0);
      end
      cyc();
    end
    chk("t6_berr_bvalid", m_bvalid, 2'b01);
    chk("t6_berr_bpld", m_bpld[5:0], {4'd5, 2'b10});
    chk("t6_timeout_err", timeout_err, 1);
    chk("t6_berr_sbready", s_bready, 0);
    m_bready[0] = 1'b1;
    cyc();
    m_bready = '0;
    #1;
    chk("t6_idle", busy, 0);
    chk("t6_stale_bready", s_bready, 1);
    chk("t6_sticky", timeout_err, 1);
    s_bvalid = 1'b1;
    s_bpld = {4'd5, 2'b00};
    #1;
    chk("t6_late_not_fwd", m_bvalid, 0);
    cyc();
    s_bvalid = 1'b0;
    #1;
    chk("t6_stale_clear", s_bready, 0);
`else
    chk("no_tmo_err", timeout_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
- N-master to 1-slave AXI write-channel arbiter covering the AW, W and B channels.
- Grants one master at a time with round-robin priority.
- Holds the grant through the address phase, all data beats and the write response, so only one write transaction is outstanding at a time.
- Sits between the master agents/DUT masters and the single slave port of the AXI fabric in the testbench top.

Parameters:
- NUM_M, 2, number of requesting masters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- ID_W, 4, AWID/BID width.
- TIMEOUT_CYC, 256, write-response watchdog limit in cycles; used only with the optional feature.

Ports:
- aclk  in  1  clock; all logic on its rising edge.
- arst  in  1  synchronous active-high reset.
- m_awvalid  in  NUM_M  per-master AWVALID.
- m_awready  out  NUM_M  per-master AWREADY.
- m_awpld  in  NUM_M*AW_W  per-master {awid, awaddr, awlen[7:0]}; AW_W = ID_W+ADDR_W+8.
- m_wvalid  in  NUM_M  per-master WVALID.
- m_wready  out  NUM_M  per-master WREADY.
- m_wpld  in  NUM_M*W_W  per-master {wdata, wstrb, wlast}.
- m_bvalid  out  NUM_M  per-master BVALID.
- m_bready  in  NUM_M  per-master BREADY.
- m_bpld  out  NUM_M*B_W  per-master {bid, bresp[1:0]}.
- s_awvalid / s_awready  out / in  1  slave AW handshake.
- s_awpld  out  AW_W  selected AW payload.
- s_wvalid / s_wready  out / in  1  slave W handshake.
- s_wpld  out  W_W  selected W payload.
- s_bvalid / s_bready  in / out  1  slave B handshake.
- s_bpld  in  B_W  slave {bid, bresp}.
- grant  out  $clog2(NUM_M)  index of the current owner; valid while busy=1.
- busy  out  1  high in every state other than IDLE.
- timeout_err  out  1  sticky response-timeout flag; tied 0 without the optional feature.

Behaviour:
- Reset: state=IDLE; last_grant=NUM_M-1, so master 0 has first priority.
- Reset values: all valid/ready outputs 0; grant=0; busy=0; timeout_err=0; beat counter=0.
- Reset asserted mid-transaction abandons the transaction. Outputs are at reset values after that edge, and no response is delivered to the master.
- FSM IDLE -> AW -> W -> B -> IDLE.
- IDLE, arbitration: if any m_awvalid is high, choose the first requester searching from last_grant+1 with wrap-around.
- IDLE, grant capture: register grant and capture the AW payload. Move to AW on the next edge.
- Arbitration latency: m_awvalid seen in cycle N gives s_awvalid=1 in cycle N+1.
- AW state:
  - s_awvalid=1; s_awpld is driven from the granted master's live payload.
  - m_awready[grant]=s_awready; every other m_awready=0.
  - On the s_awvalid&s_awready edge: go to W, load beat counter with awlen.
- W state:
  - s_wvalid=m_wvalid[grant]; m_wready[grant]=s_wready; s_wpld=granted m_wpld.
  - Each handshake decrements the counter.
  - The transaction exits to B on a handshake with wlast=1.
  - wlast arriving with counter!=0, or counter==0 without wlast: the arbiter still exits on wlast. A mismatch does not stall it; it is reported only by the bench's checker.
  - W beats presented before the AW phase completes are not accepted: wready=0 in IDLE and AW.
- B state:
  - m_bvalid[grant]=s_bvalid; m_bpld[grant]=s_bpld; s_bready=m_bready[grant].
  - On the B handshake: last_grant<=grant, go to IDLE.
  - A new grant cannot occur in the same cycle as the B handshake. The minimum gap between transactions is 1 IDLE cycle.
- Non-granted masters see ready=0 and bvalid=0 at all times; their requests remain pending.
- A master that drops m_awvalid before the AW handshake violates AXI. The arbiter stays in AW, driving the now-stale payload.
- Single requester: that master is re-granted each time through IDLE.

Optional Feature:
- Macro: AXI_WARB_BTIMEOUT_EN.
- When defined, a counter runs in B and is cleared on entry to B.
- If s_bvalid has not arrived when the count reaches TIMEOUT_CYC-1, the arbiter moves to BERR.
- BERR: drives m_bvalid[grant]=1 with bid=captured awid and bresp=2'b10 (SLVERR), and sets timeout_err (sticky until reset).
- BERR exits to IDLE on m_bready, setting a stale flag.
- While the stale flag is set, s_bready=1 in IDLE, AW and W. The next s_bvalid is discarded and clears the flag.
- When the macro is undefined: no BERR state, no counter, timeout_err=0, and B waits indefinitely.

Decomposition:
- Package axi_warb_pkg: AW_W/W_W/B_W localparams, typedefs aw_pld_t / w_pld_t / b_pld_t, state enum, and RESP_SLVERR=2'b10.
- One sub-module: axi_rr_arbiter, a combinational round-robin pick from req vector and last_grant, returning a one-hot vector and an index.

Test Plan:
- Single master, 4-beat burst:
  - Stimulus: m_awvalid[0] with awid=3, addr=0x100, awlen=3; slave awready after 2 cycles; 4 W beats; bresp=OKAY.
  - Required: s_awvalid in cycle N+1, 4 W beats forwarded in order, m_bvalid[0] with bid=3/OKAY, busy low 1 cycle after the B handshake.
- Two masters request in the same cycle from reset:
  - Required: master 0 granted first, master 1 second.
  - Repeat with both requesting again: master 0 is granted first again (after a grant to 1, priority returns to 0), i.e. strict alternation.
- While master 0 is in W, master 1 raises awvalid and wvalid:
  - Required: m_awready[1]=m_wready[1]=0 until master 0's B handshake; master 1 granted on the next IDLE.
- Slave backpressure: s_wready toggles 1-0-1-0 during an 8-beat burst.
  - Required: exactly 8 handshakes, no duplicated or dropped beats, exit to B on wlast.
- arst pulsed in W after 2 of 4 beats:
  - Required: all outputs 0 on the next edge, state IDLE, and the next arbitration grants master 0.
- With AXI_WARB_BTIMEOUT_EN and TIMEOUT_CYC=16, slave withholds bvalid:
  - Required: after 16 cycles in B, m_bvalid[grant] with bresp=2'b10 and timeout_err=1.
  - A late s_bvalid is absorbed via s_bready=1 and not forwarded.
